// File: rtl/iir_section2_inverse.sv
// iir_section2_inverse
//   Inverse FIR equaliser of the second-order IIR section:
//     y[n] = B0*x[n] + B1*x[n-1] + B2*x[n-2]
//   One shared 11x13 multiplier is time-multiplexed over three MAC states.
//   Samples and results are signed Q1.10. Coefficients are signed Q3.10.
//
//   Optional build macro IIR_INV_ROUND_EN:
//     defined     -> scale() rounds half up: (acc + 512) >>> 10
//     not defined -> scale() truncates toward -infinity: acc >>> 10
//   Saturation to 11 bits is applied after scaling in both builds.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous reset, active-high
//   x        in   11  input sample, signed Q1.10
//   x_valid  in   1   x is valid this cycle
//   x_ready  out  1   block can accept x this cycle (decoded from state)
//   y        out  11  output sample, signed Q1.10, held until next result
//   y_valid  out  1   one-cycle pulse when y updates
module iir_section2_inverse #(
  parameter logic signed [12:0] B0 = 13'sd1024,
  parameter logic signed [12:0] B1 = -13'sd1434,
  parameter logic signed [12:0] B2 = 13'sd614
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] x,
  input  logic               x_valid,
  output logic               x_ready,
  output logic signed [10:0] y,
  output logic               y_valid
);

  localparam int unsigned XW = 11;
  localparam int unsigned CW = 13;
  localparam int unsigned PW = 24;
  localparam int unsigned AW = 26;
  localparam int unsigned SH = 10;

  localparam logic signed [AW-1:0] Y_MAX = 26'sd1023;
  localparam logic signed [AW-1:0] Y_MIN = -26'sd1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t state;

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] d1;
  logic signed [XW-1:0] d2;
  logic signed [AW-1:0] acc;

  logic signed [CW-1:0] coef;
  logic signed [XW-1:0] samp;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] scaled;
  logic signed [XW-1:0] y_sat;

  assign x_ready = (state == IDLE);

  // Operand select for the shared multiplier, one tap per MAC state.
  always_comb begin
    coef = B0;
    samp = xs;
    case (state)
      MAC1: begin
        coef = B1;
        samp = d1;
      end
      MAC2: begin
        coef = B2;
        samp = d2;
      end
      default: begin
        coef = B0;
        samp = xs;
      end
    endcase
    prod = PW'(coef) * PW'(samp);
  end

  // Scale back to Q1.10 and clamp so no wrap-around reaches y.
  always_comb begin
`ifdef IIR_INV_ROUND_EN
    biased = acc + 26'sd512;
`else
    biased = acc;
`endif
    scaled = biased >>> SH;
    if (scaled > Y_MAX) begin
      y_sat = 11'sd1023;
    end else if (scaled < Y_MIN) begin
      y_sat = -11'sd1024;
    end else begin
      y_sat = scaled[XW-1:0];
    end
  end

  // Sequencer: IDLE -> MAC0 -> MAC1 -> MAC2 -> OUT -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      xs      <= '0;
      d1      <= '0;
      d2      <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            xs    <= x;
            acc   <= '0;
            state <= MAC0;
          end
        end
        MAC0: begin
          acc   <= acc + AW'(prod);
          state <= MAC1;
        end
        MAC1: begin
          acc   <= acc + AW'(prod);
          state <= MAC2;
        end
        MAC2: begin
          acc   <= acc + AW'(prod);
          state <= OUT;
        end
        OUT: begin
          y       <= y_sat;
          y_valid <= 1'b1;
          d2      <= d1;
          d1      <= xs;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
